// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift engine: FSM states, frame-length
// normalisation and the smallest data width the engine supports.
package spi_pkg;

  localparam int SPI_MIN_DATA_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // A frame length of zero or anything wider than the data path means "full width".
  function automatic int spiNormLen(input int len, input int maxLen);
    return ((len == 0) || (len > maxLen)) ? maxLen : len;
  endfunction

endpackage

// File: rtl/spi_edge_select.sv
// Maps the baud generator's lead/trail strobes onto drive/sample strobes for
// the latched clock phase; a lead strobe always wins over a coincident trail.
module spi_edge_select (
  input  logic i_lead_stb,
  input  logic i_trail_stb,
  input  logic i_cpha,
  output logic o_drive_stb,
  output logic o_sample_stb
);

  logic w_trail;

  assign w_trail      = i_trail_stb & ~i_lead_stb;
  assign o_drive_stb  = i_cpha ? i_lead_stb : w_trail;
  assign o_sample_stb = i_cpha ? w_trail : i_lead_stb;

endmodule

// File: rtl/spi_shift_engine.sv
// Parametrised SPI shift engine: serialises mosidata, assembles misodata.
// Define SPI_SHIFT_RXBUF_EN to add the receive holding register (rx_full/rx_overrun).
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              ss,
  input  logic              senddata,
  input  logic              lsbfe,
  input  logic              cpha,
  input  logic              lead_stb,
  input  logic              trail_stb,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] mosidata,
  input  logic              miso,
`ifdef SPI_SHIFT_RXBUF_EN
  input  logic              rx_ack,
  output logic              rx_full,
  output logic              rx_overrun,
`endif
  output logic              mosi,
  output logic [DATA_W-1:0] misodata,
  output logic              rx_valid,
  output logic              busy
);

  if ((DATA_W < SPI_MIN_DATA_W) || (DATA_W > 32)) begin : gBadDataW
    $error("spi_shift_engine: DATA_W out of range");
  end

  spi_state_e        r_state, w_stateNext;
  logic [DATA_W-1:0] r_tx, r_rx, r_misodata, w_rxNext;
  logic [CNT_W-1:0]  r_cnt, r_len, w_lenNorm, w_bitPos, w_loadPos;
  logic              r_lsbfe, r_cpha, r_mosi, r_rxValid;
  logic              w_active, w_load, w_driveStb, w_sampleStb;
  logic              w_drive, w_sample, w_last, w_txBit, w_loadBit;

  assign w_lenNorm = CNT_W'(spiNormLen(int'(frame_len), DATA_W));
  assign w_active  = (r_state == ACTIVE);
  assign w_load    = !w_active && senddata && !ss;

  spi_edge_select u_edgeSelect (
    .i_lead_stb  (lead_stb),
    .i_trail_stb (trail_stb),
    .i_cpha      (r_cpha),
    .o_drive_stb (w_driveStb),
    .o_sample_stb(w_sampleStb)
  );

  // Dropping ss mid-frame takes priority over any strobe in the same cycle.
  assign w_drive  = w_active && !ss && w_driveStb && (r_cnt < r_len);
  assign w_sample = w_active && !ss && w_sampleStb;
  assign w_last   = w_sample && ((r_cnt + CNT_W'(1)) == r_len);

  // Bit k of the frame lives at position k (LSB first) or len-1-k (MSB first).
  assign w_bitPos  = r_lsbfe ? r_cnt : (r_len - CNT_W'(1) - r_cnt);
  assign w_loadPos = lsbfe ? '0 : (w_lenNorm - CNT_W'(1));
  assign w_txBit   = |(r_tx & (DATA_W'(1) << w_bitPos));
  assign w_loadBit = |(mosidata & (DATA_W'(1) << w_loadPos));
  assign w_rxNext  = r_rx | (DATA_W'(miso) << w_bitPos);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_load) w_stateNext = ACTIVE;
      ACTIVE:  if (ss || w_last) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tx    <= '0;
      r_rx    <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_lsbfe <= 1'b0;
      r_cpha  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx    <= mosidata;
        r_rx    <= '0;
        r_cnt   <= '0;
        r_len   <= w_lenNorm;
        r_lsbfe <= lsbfe;
        r_cpha  <= cpha;
        if (!cpha) r_mosi <= w_loadBit;
      end
      if (w_drive) r_mosi <= w_txBit;
      if (w_sample) begin
        r_rx  <= w_rxNext;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SPI_SHIFT_RXBUF_EN
  logic r_rxFull, r_rxOverrun, w_fullAfterAck;

  // An ack arriving with a completion frees the buffer before the new word lands.
  assign w_fullAfterAck = r_rxFull && !rx_ack;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_misodata  <= '0;
      r_rxValid   <= 1'b0;
      r_rxFull    <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (w_last && !w_fullAfterAck) begin
        r_misodata  <= w_rxNext;
        r_rxValid   <= 1'b1;
        r_rxFull    <= 1'b1;
        r_rxOverrun <= r_rxOverrun && !rx_ack;
      end else if (w_last) begin
        r_rxOverrun <= 1'b1;
      end else if (rx_ack) begin
        r_rxFull    <= 1'b0;
        r_rxOverrun <= 1'b0;
      end
    end
  end

  assign rx_full    = r_rxFull;
  assign rx_overrun = r_rxOverrun;
`else
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_misodata <= '0;
      r_rxValid  <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (w_last) begin
        r_misodata <= w_rxNext;
        r_rxValid  <= 1'b1;
      end
    end
  end
`endif

  assign mosi     = r_mosi;
  assign misodata = r_misodata;
  assign rx_valid = r_rxValid;
  assign busy     = w_active;

endmodule
